// File: rtl/mips_dbus_uart_tx_pkg.sv
// Register map, STATUS bit positions and serializer states for the data-bus UART transmitter.
package mips_dbus_uart_tx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_IE        = 4;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/mips_dbus_uart_tx_fifo.sv
// Generic synchronous FIFO with combinational read port and occupancy count.
module mips_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = count == FULL_COUNT;
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data bus: TX FIFO, divisor, status and serializer.
module mips_dbus_uart_tx
    import mips_dbus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'hFFFF0000,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [15:0] DIV_INIT   = 16'd433
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DA,
    input  logic [3:0]  we,
    input  logic [31:0] DO,
    input  logic        re,
    output logic [31:0] DI,
    output logic        txd,
    output logic        irq
);
    logic                sel;
    logic [1:0]          off;
    logic                push_req;
    logic                pop;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic [7:0]          fifo_dout;
    tx_state_t           state;
    logic [7:0]          shift;
    logic [15:0]         bit_cnt;
    logic [2:0]          bit_idx;
    logic                bit_done;
    logic                ovf;
    logic                ie;
    logic [15:0]         div;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign sel         = DA[31:4] == BASE[31:4];
    assign off         = DA[3:2];
    assign push_req    = sel & we[0] & (off == REG_DATA);
    assign bit_done    = bit_cnt == '0;
    assign pop         = !empty & ((state == TX_IDLE) | ((state == TX_STOP) & bit_done));
    assign irq         = ie & !full;
    assign unused_bits = ^{DA[1:0], DO[31:16], we[3:2]};

    mips_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (DO[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            ie  <= 1'b0;
            div <= DIV_INIT;
        end else begin
            if (push_req & full & !pop) ovf <= 1'b1;
            if (sel & we[0] & (off == REG_STATUS)) begin
                if (DO[3]) ovf <= 1'b0;
                ie <= DO[4];
            end
            if (sel & (off == REG_DIV)) begin
                if (we[0]) div[7:0]  <= DO[7:0];
                if (we[1]) div[15:8] <= DO[15:8];
            end
        end
    end

    // Bit counter reloads from the live divisor at every bit boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            txd     <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_dout;
                        bit_cnt <= div;
                        txd     <= 1'b0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        txd     <= shift[0];
                        bit_idx <= '0;
                        bit_cnt <= div;
                        state   <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= div;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            txd     <= shift[1];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift   <= fifo_dout;
                            bit_cnt <= div;
                            txd     <= 1'b0;
                            state   <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            REG_STATUS: begin
                rdata[ST_BUSY]               = state != TX_IDLE;
                rdata[ST_FULL]               = full;
                rdata[ST_EMPTY]              = empty;
                rdata[ST_OVF]                = ovf;
                rdata[ST_IE]                 = ie;
                rdata[ST_COUNT_LSB +: 4]     = 4'(count);
            end
            REG_DIV:  rdata[15:0] = div;
            default:  rdata = '0;
        endcase
        DI = (sel & re) ? rdata : '0;
    end

endmodule

// File: tb/tb_mips_dbus_uart_tx.sv
// Self-checking bench: frame-schedule reference model predicts txd, STATUS and irq cycle by cycle.
module tb_mips_dbus_uart_tx;
    localparam logic [31:0] BASE    = 32'hFFFF0000;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] A_DATA  = BASE;
    localparam logic [31:0] A_STAT  = BASE | 32'h4;
    localparam logic [31:0] A_DIV   = BASE | 32'h8;
    localparam logic [31:0] A_RSV   = BASE | 32'hC;
    localparam logic [31:0] A_OTHER = 32'h1000_0004;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] DA, DO, DI;
    logic [3:0]  we;
    logic        re;
    logic        txd, irq;

    mips_dbus_uart_tx #(
        .BASE       (BASE),
        .DEPTH_LOG2 (2),
        .DIV_INIT   (16'd433)
    ) dut (
        .clock (clock),
        .reset (reset),
        .DA    (DA),
        .we    (we),
        .DO    (DO),
        .re    (re),
        .DI    (DI),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: every accepted byte becomes a frame with a start edge on the line.
    typedef struct {
        int         acc;
        int         start;
        int         div;
        logic [7:0] data;
    } frame_t;

    frame_t      frames[$];
    logic [15:0] m_div;
    bit          m_ovf;
    bit          m_ie;

    function automatic int flen(input int d);
        return 10 * (d + 1);
    endfunction

    function automatic int occ(input int c);
        int n = 0;
        foreach (frames[i])
            if (frames[i].acc <= c && frames[i].start > c) n++;
        return n;
    endfunction

    function automatic int model_end();
        int e = 0;
        foreach (frames[i])
            if (frames[i].start + flen(frames[i].div) > e) e = frames[i].start + flen(frames[i].div);
        return e;
    endfunction

    function automatic bit exp_busy(input int c);
        foreach (frames[i])
            if (frames[i].start <= c && c < frames[i].start + flen(frames[i].div)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_txd(input int c);
        int k;
        foreach (frames[i]) begin
            if (frames[i].start <= c && c < frames[i].start + flen(frames[i].div)) begin
                k = (c - frames[i].start) / (frames[i].div + 1);
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return frames[i].data[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status(input int c);
        logic [31:0] s = '0;
        int n = occ(c);
        s[0]    = exp_busy(c);
        s[1]    = (n == DEPTH);
        s[2]    = (n == 0);
        s[3]    = m_ovf;
        s[4]    = m_ie;
        s[11:8] = 4'(n);
        return s;
    endfunction

    function automatic logic exp_irq(input int c);
        return m_ie & (occ(c) != DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data, input int e);
        frame_t f;
        int     st;
        if (addr[31:4] != BASE[31:4]) return;
        case (addr[3:2])
            2'd0: if (be[0]) begin
                if (occ(e) >= DEPTH) m_ovf = 1'b1;
                else begin
                    st      = model_end();
                    f.acc   = e;
                    f.start = (e + 1 > st) ? e + 1 : st;
                    f.div   = int'(m_div);
                    f.data  = data[7:0];
                    frames.push_back(f);
                end
            end
            2'd1: if (be[0]) begin
                if (data[3]) m_ovf = 1'b0;
                m_ie = data[4];
            end
            2'd2: begin
                if (be[0]) m_div[7:0]  = data[7:0];
                if (be[1]) m_div[15:8] = data[15:8];
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        frames.delete();
        m_div = 16'd433;
        m_ovf = 1'b0;
        m_ie  = 1'b0;
    endtask

    bit mon_en = 1'b0;
    always @(negedge clock) begin
        if (mon_en) begin
            check("txd", 32'(txd), 32'(exp_txd(cyc)));
            check("irq", 32'(irq), 32'(exp_irq(cyc)));
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        @(negedge clock);
        DA = addr; we = be; DO = data; re = 1'b0;
        @(posedge clock);
        #1;
        we = '0;
        model_write(addr, be, data, cyc);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic rd, output logic [31:0] data);
        @(negedge clock);
        DA = addr; we = '0; re = rd;
        #1;
        data = DI;
        re = 1'b0;
    endtask

    task automatic watch(input int extra);
        int          target;
        logic [31:0] d;
        target = ((model_end() > cyc) ? model_end() : cyc) + extra;
        while (cyc < target) begin
            bus_read(A_STAT, 1'b1, d);
            check("status", d, exp_status(cyc));
        end
    endtask

    logic [31:0] rd;
    int          s;
    logic [7:0]  b0;

    initial begin
        reset = 1'b1; DA = '0; we = '0; DO = '0; re = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        mon_en = 1'b1;

        bus_read(A_STAT, 1'b1, rd);  check("status_rst", rd, exp_status(cyc));
        bus_read(A_DIV, 1'b1, rd);   check("div_rst", rd, {16'h0, m_div});
        bus_read(A_DIV, 1'b0, rd);   check("re_low", rd, 32'h0);
        bus_read(A_OTHER, 1'b1, rd); check("not_sel", rd, 32'h0);
        bus_read(A_DATA, 1'b1, rd);  check("data_rd", rd, 32'h0);
        bus_read(A_RSV, 1'b1, rd);   check("rsv_rd", rd, 32'h0);

        bus_write(A_DIV, 4'b0001, 32'h7);
        bus_read(A_DIV, 1'b1, rd);   check("div_lane0", rd, {16'h0, m_div});
        bus_write(A_RSV, 4'b1111, 32'hFFFF_FFFF);
        bus_write(A_OTHER, 4'b1111, 32'hFFFF_FFFF);
        bus_read(A_DIV, 1'b1, rd);   check("div_keep", rd, {16'h0, m_div});

        // Stores that must not push: wrong lane, or outside the block.
        bus_write(A_DATA, 4'b0010, 32'h0000_AA00);
        bus_write(A_DATA, 4'b1100, 32'hAA00_0000);
        bus_write(32'h1000_0000, 4'b0001, 32'h11);
        watch(5);

        bus_write(A_DIV, 4'b0011, 32'd3);
        bus_write(A_DATA, 4'b0001, 32'h55);
        watch(3);

        bus_write(A_DIV, 4'b0011, 32'd0);
        bus_write(A_DATA, 4'b0001, 32'hA5);
        bus_write(A_DATA, 4'b0001, 32'h3C);
        bus_write(A_DATA, 4'b0001, $urandom);
        bus_write(A_DATA, 4'b0001, $urandom);
        watch(3);

        bus_write(A_DIV, 4'b0011, 32'd9);
        for (int i = 0; i < 6; i++) bus_write(A_DATA, 4'b0001, $urandom);
        bus_read(A_STAT, 1'b1, rd);  check("status_ovf", rd, exp_status(cyc));
        bus_write(A_STAT, 4'b0001, 32'h18);
        bus_read(A_STAT, 1'b1, rd);  check("status_ie", rd, exp_status(cyc));
        watch(3);
        bus_write(A_STAT, 4'b0001, 32'h08);
        bus_read(A_STAT, 1'b1, rd);  check("status_clr", rd, exp_status(cyc));

        for (int r = 0; r < 6; r++) begin
            int d;
            int n;
            d = $urandom_range(0, 2);
            n = $urandom_range(1, 7);
            bus_write(A_DIV, 4'b0011, 32'(d));
            bus_write(A_STAT, 4'b0001, $urandom & 32'h18);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                bus_write(A_DATA, 4'b0001, $urandom);
            end
            bus_write(A_STAT, 4'b0001, $urandom & 32'h18);
            watch(3);
        end

        // Reset in the middle of data bit 3 with another byte still queued.
        bus_write(A_DIV, 4'b0011, 32'd3);
        b0 = 8'($urandom) & 8'hF7;
        bus_write(A_DATA, 4'b0001, {24'h0, b0});
        s = frames[frames.size()-1].start;
        bus_write(A_DATA, 4'b0001, $urandom);
        while (cyc < s + 17) @(negedge clock);
        #1;
        check("txd_pre_reset", 32'(txd), 32'(exp_txd(cyc)));
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check("txd_async_reset", 32'(txd), 32'h1);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mon_en = 1'b1;
        bus_read(A_STAT, 1'b1, rd);  check("status_after_rst", rd, exp_status(cyc));
        bus_read(A_DIV, 1'b1, rd);   check("div_after_rst", rd, {16'h0, m_div});
        watch(30);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
